// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arb_mux streaming multiplexer: mode encodings
// and the grant-vector to channel-index conversion.
package arb_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Widest supported channel count; grant vectors are zero-extended to this.
    localparam int MAX_N = 16;

    // Convert a one-hot (or all-zero) grant vector to a binary channel index.
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Round-robin grant generator: rotates the request vector so the channel after
// ptr sits at bit 0, picks the lowest set bit, and rotates the pick back.
module rr_grant #(
    parameter int N = 4,
    localparam int CW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [N-1:0] rot;
    logic [N-1:0] rot_pick;

    // Lowest set bit of the rotated request vector is the winner.
    assign rot_pick = rot & (~rot + N'(1));

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            // Bit gi of the rotated view is channel (ptr + 1 + gi) mod N.
            assign rot[gi]   = req[CW'((int'(ptr) + 1 + gi) % N)];
            // Channel gi lives at rotated position (gi - ptr - 1) mod N.
            assign grant[gi] = rot_pick[CW'((gi + 2 * N - 1 - int'(ptr)) % N)];
        end
    endgenerate

endmodule

// File: rtl/arb_mux.sv
// N-channel registered multiplexer with valid/ready on every input and on the
// output. Channel choice is an explicit select, or round-robin among valid
// channels when built with ARB_MUX_RR_EN defined and mode is high. Without
// ARB_MUX_RR_EN the pointer and arbiter are absent and mode is ignored.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    localparam int CW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [CW-1:0]   sel,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [CW-1:0]   out_chan,
    input  logic            out_ready
);

    logic            out_valid_reg;
    logic [W-1:0]    out_data_reg;
    logic [CW-1:0]   out_chan_reg;

    logic            load;
    logic [N-1:0]    fixed_grant;
    logic [N-1:0]    grant;
    logic [N-1:0]    transfer;
    logic            any_transfer;
    logic [CW-1:0]   chan_idx;
    logic [W-1:0]    data_mask [N];
    logic [W-1:0]    data_next;

    // The output register can take a beat when empty or being drained.
    assign load = !out_valid_reg | out_ready;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            // Fixed select ignores in_valid; an out-of-range sel matches nothing.
            assign fixed_grant[gi] = (sel == CW'(gi));
            assign data_mask[gi]   = grant[gi] ? in_data[gi*W +: W] : '0;
        end
    endgenerate

`ifdef ARB_MUX_RR_EN
    logic [CW-1:0] ptr_reg;
    logic [N-1:0]  rr_grant_vec;

    rr_grant #(.N(N)) u_rr_grant (
        .req   (in_valid),
        .ptr   (ptr_reg),
        .grant (rr_grant_vec)
    );

    assign grant = (mode == MODE_RR) ? rr_grant_vec : fixed_grant;

    // Pointer remembers the last round-robin winner; fixed-mode beats leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= CW'(N - 1);
        end else if (mode == MODE_RR && any_transfer) begin
            ptr_reg <= chan_idx;
        end
    end
`else
    logic mode_unused;
    assign mode_unused = mode;
    assign grant       = fixed_grant;
`endif

    assign in_ready     = rst ? '0 : (grant & {N{load}});
    assign transfer     = in_valid & in_ready;
    assign any_transfer = |transfer;
    assign chan_idx     = CW'(onehot_to_idx(MAX_N'(grant)));

    // Grant is one-hot, so OR-ing the masked channels selects the winner's data.
    always_comb begin
        data_next = '0;
        for (int i = 0; i < N; i++) begin
            data_next = data_next | data_mask[i];
        end
    end

    // Output register: load a new beat on transfer, otherwise empty out when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
        end else if (load) begin
            out_valid_reg <= any_transfer;
            if (any_transfer) begin
                out_data_reg <= data_next;
                out_chan_reg <= chan_idx;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;

endmodule
